// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller: tracks in-flight destinations after ID and raises stall/bubble
// for read-after-write conflicts and flush for branch/jump redirects.
module pipeline_hazard_ctrl #(
  parameter int STAGES         = 3,
  parameter int REG_ADDR_W     = 5,
  parameter int FORWARDING     = 1,
  parameter int REDIRECT_STAGE = 1,
  parameter int CNT_W          = 32
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  enable,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  redirect,
  output logic                  stall,
  output logic                  bubble,
  output logic                  flush,
  output logic [STAGES-1:0]     stage_valid,
  output logic [CNT_W-1:0]      retired_cnt,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  logic [STAGES-1:0]     ent_valid;
  logic [STAGES-1:0]     ent_rw;
  logic [STAGES-1:0]     ent_mr;
  logic [REG_ADDR_W-1:0] ent_rd [STAGES];
  logic [STAGES-1:0]     src_match;
  logic                  hazard;

  always_comb begin
    src_match = '0;
    for (int i = 0; i < STAGES; i++) begin
      src_match[i] = ent_valid[i] & ent_rw[i] & (ent_rd[i] != '0) &
                     ((id_rs1_used & (id_rs1 == ent_rd[i])) |
                      (id_rs2_used & (id_rs2 == ent_rd[i])));
    end
  end

  // With forwarding only a load still in EXE conflicts; without it, any producer
  // short of WB does, since the register file writes through.
  generate
    if (FORWARDING != 0) begin : g_fwd
      assign hazard = src_match[0] & ent_mr[0];
    end else begin : g_nofwd
      assign hazard = |src_match[STAGES-2:0];
    end
  endgenerate

  assign stall       = id_valid & hazard & ~redirect;
  assign bubble      = stall;
  assign flush       = redirect;
  assign stage_valid = ent_valid;

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      ent_valid   <= '0;
      ent_rw      <= '0;
      ent_mr      <= '0;
      for (int i = 0; i < STAGES; i++) ent_rd[i] <= '0;
      retired_cnt <= '0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else if (enable) begin
      for (int i = STAGES - 1; i >= 1; i--) begin
        if (redirect && (i < REDIRECT_STAGE)) begin
          ent_valid[i] <= 1'b0;
          ent_rw[i]    <= 1'b0;
          ent_mr[i]    <= 1'b0;
          ent_rd[i]    <= '0;
        end else begin
          ent_valid[i] <= ent_valid[i-1];
          ent_rw[i]    <= ent_rw[i-1];
          ent_mr[i]    <= ent_mr[i-1];
          ent_rd[i]    <= ent_rd[i-1];
        end
      end
      if (stall || flush) begin
        ent_valid[0] <= 1'b0;
        ent_rw[0]    <= 1'b0;
        ent_mr[0]    <= 1'b0;
        ent_rd[0]    <= '0;
      end else begin
        ent_valid[0] <= id_valid;
        ent_rw[0]    <= id_reg_write;
        ent_mr[0]    <= id_mem_read;
        ent_rd[0]    <= id_rd;
      end
      retired_cnt <= retired_cnt + {{(CNT_W-1){1'b0}}, ent_valid[STAGES-1]};
      stall_cnt   <= stall_cnt + {{(CNT_W-1){1'b0}}, stall};
      flush_cnt   <= flush_cnt + {{(CNT_W-1){1'b0}}, redirect};
    end
  end

  // The WB entry only contributes its valid bit (it never forwards or conflicts).
  logic unused_wb_fields;
  assign unused_wb_fields = ^{ent_rd[STAGES-1], ent_rw[STAGES-1], ent_mr[STAGES-1], src_match};

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized and directed bench for pipeline_hazard_ctrl; two configurations share
// one input stream and are each checked against a queue-style reference model.
module tb_pipeline_hazard_ctrl;

  logic       clk;
  logic       arst_n;
  logic       enable;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_rs1_used, id_rs2_used, id_reg_write, id_mem_read, redirect;

  logic        stall_a, bubble_a, flush_a;
  logic [2:0]  sv_a;
  logic [31:0] ret_a, stc_a, flc_a;
  logic        stall_b, bubble_b, flush_b;
  logic [2:0]  sv_b;
  logic [3:0]  ret_b, stc_b, flc_b;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
  } ent_t;

  ent_t        mdl [2][3];
  logic [31:0] cnt [2][3];

  pipeline_hazard_ctrl dut_a (
    .clk(clk), .arst_n(arst_n), .enable(enable), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .redirect(redirect),
    .stall(stall_a), .bubble(bubble_a), .flush(flush_a), .stage_valid(sv_a),
    .retired_cnt(ret_a), .stall_cnt(stc_a), .flush_cnt(flc_a)
  );

  pipeline_hazard_ctrl #(
    .STAGES(3), .REG_ADDR_W(5), .FORWARDING(0), .REDIRECT_STAGE(2), .CNT_W(4)
  ) dut_b (
    .clk(clk), .arst_n(arst_n), .enable(enable), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .redirect(redirect),
    .stall(stall_b), .bubble(bubble_b), .flush(flush_b), .stage_valid(sv_b),
    .retired_cnt(ret_b), .stall_cnt(stc_b), .flush_cnt(flc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Unit 0 forwards (only a load in EXE conflicts); unit 1 does not, so any
  // producer not yet in WB conflicts.
  function automatic logic hazardOf(int u);
    logic h;
    ent_t e;
    int   lim;
    h   = 1'b0;
    lim = (u == 0) ? 0 : 1;
    for (int k = 0; k <= lim; k++) begin
      e = mdl[u][k];
      if (e.v && e.rw && e.rd != 0 && (u != 0 || e.mr) &&
          ((id_rs1_used && id_rs1 == e.rd) || (id_rs2_used && id_rs2 == e.rd)))
        h = 1'b1;
    end
    return h;
  endfunction

  function automatic logic expStall(int u);
    return id_valid && hazardOf(u) && !redirect;
  endfunction

  function automatic logic [31:0] expSv(int u);
    return {29'b0, mdl[u][2].v, mdl[u][1].v, mdl[u][0].v};
  endfunction

  task automatic modelStep();
    logic st;
    ent_t idEnt;
    int   rstage;
    logic [31:0] mask;
    idEnt = '{v: id_valid, rd: id_rd, rw: id_reg_write, mr: id_mem_read};
    for (int u = 0; u < 2; u++) begin
      rstage = (u == 0) ? 1 : 2;
      mask   = (u == 0) ? 32'hFFFF_FFFF : 32'h0000_000F;
      if (!arst_n) begin
        for (int k = 0; k < 3; k++) begin
          mdl[u][k] = '0;
          cnt[u][k] = '0;
        end
      end else if (enable) begin
        st = expStall(u);
        cnt[u][0] = (cnt[u][0] + (mdl[u][2].v ? 1 : 0)) & mask;
        cnt[u][1] = (cnt[u][1] + (st ? 1 : 0)) & mask;
        cnt[u][2] = (cnt[u][2] + (redirect ? 1 : 0)) & mask;
        mdl[u][2] = mdl[u][1];
        mdl[u][1] = mdl[u][0];
        mdl[u][0] = (st || redirect) ? ent_t'('0) : idEnt;
        if (redirect)
          for (int k = 1; k < rstage; k++) mdl[u][k] = '0;
      end
    end
  endtask

  task automatic checkAll();
    checkOutput("a.stall",  {31'b0, stall_a},  {31'b0, expStall(0)});
    checkOutput("a.bubble", {31'b0, bubble_a}, {31'b0, expStall(0)});
    checkOutput("a.flush",  {31'b0, flush_a},  {31'b0, redirect});
    checkOutput("a.sv",     {29'b0, sv_a},     expSv(0));
    checkOutput("a.ret",    ret_a,             cnt[0][0]);
    checkOutput("a.stcnt",  stc_a,             cnt[0][1]);
    checkOutput("a.flcnt",  flc_a,             cnt[0][2]);
    checkOutput("b.stall",  {31'b0, stall_b},  {31'b0, expStall(1)});
    checkOutput("b.bubble", {31'b0, bubble_b}, {31'b0, expStall(1)});
    checkOutput("b.flush",  {31'b0, flush_b},  {31'b0, redirect});
    checkOutput("b.sv",     {29'b0, sv_b},     expSv(1));
    checkOutput("b.ret",    {28'b0, ret_b},    cnt[1][0]);
    checkOutput("b.stcnt",  {28'b0, stc_b},    cnt[1][1]);
    checkOutput("b.flcnt",  {28'b0, flc_b},    cnt[1][2]);
  endtask

  // One clock: drive at the falling edge, check mid-cycle, advance the model at
  // the rising edge. glitch pulses reset low entirely between two rising edges.
  task automatic applyStimulus(input logic rstn, input logic en, input logic v,
                               input logic [4:0] rs1, input logic u1,
                               input logic [4:0] rs2, input logic u2,
                               input logic [4:0] rd, input logic rw, input logic mr,
                               input logic redir, input logic glitch);
    @(negedge clk);
    arst_n = rstn; enable = en; id_valid = v;
    id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    id_rd = rd; id_reg_write = rw; id_mem_read = mr; redirect = redir;
    #1;
    checkAll();
    if (glitch) begin
      arst_n = 1'b0;
      #2;
      arst_n = 1'b1;
    end
    @(posedge clk);
    modelStep();
  endtask

  task automatic issue(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                       input logic u2, input logic [4:0] rd, input logic rw,
                       input logic mr, input logic redir);
    applyStimulus(1, 1, 1, rs1, u1, rs2, u2, rd, rw, mr, redir, 0);
  endtask

  task automatic idle(input logic en);
    applyStimulus(1, en, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic doReset();
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    arst_n = 0; enable = 0; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_rs1_used = 0; id_rs2_used = 0; id_reg_write = 0; id_mem_read = 0; redirect = 0;
    for (int u = 0; u < 2; u++)
      for (int k = 0; k < 3; k++) begin
        mdl[u][k] = '0;
        cnt[u][k] = '0;
      end

    @(posedge clk);
    doReset();
    doReset();
    #1;
    checkOutput("rst.sv", {29'b0, sv_a}, 32'd0);
    checkOutput("rst.stcnt", stc_a, 32'd0);

    $display("[TB] load-use");
    issue(0, 0, 0, 0, 5, 1, 1, 0);
    issue(5, 1, 0, 0, 6, 1, 0, 0);
    #1;
    checkOutput("lu.stcnt", stc_a, 32'd1);
    checkOutput("lu.sv", {29'b0, sv_a}, 32'b010);
    issue(5, 1, 0, 0, 6, 1, 0, 0);
    issue(5, 1, 0, 0, 6, 1, 0, 0);
    #1;
    checkOutput("lu.stcnt2", stc_a, 32'd1);
    checkOutput("nofwd.stcnt", {28'b0, stc_b}, 32'd2);

    $display("[TB] rd zero / unused source");
    doReset();
    issue(0, 0, 0, 0, 0, 1, 1, 0);
    issue(0, 1, 0, 0, 6, 1, 0, 0);
    issue(0, 0, 0, 0, 5, 1, 1, 0);
    issue(5, 0, 0, 0, 6, 1, 0, 0);
    #1;
    checkOutput("rd0.stcnt", stc_a, 32'd0);

    $display("[TB] alu producer without forwarding");
    doReset();
    issue(0, 0, 0, 0, 7, 1, 0, 0);
    issue(0, 0, 7, 1, 8, 1, 0, 0);
    issue(0, 0, 7, 1, 8, 1, 0, 0);
    issue(0, 0, 7, 1, 8, 1, 0, 0);
    #1;
    checkOutput("alu.stcnt_b", {28'b0, stc_b}, 32'd2);
    checkOutput("alu.stcnt_a", stc_a, 32'd0);

    $display("[TB] redirect with hazard");
    doReset();
    issue(0, 0, 0, 0, 5, 1, 1, 0);
    issue(5, 1, 0, 0, 6, 1, 0, 1);
    #1;
    checkOutput("rd.flcnt", flc_a, 32'd1);
    checkOutput("rd.stcnt", stc_a, 32'd0);
    checkOutput("rd.sv0", {31'b0, sv_a[0]}, 32'd0);

    $display("[TB] retire wrap and freeze");
    doReset();
    for (int i = 0; i < 17; i++) issue(1, 0, 2, 0, 3, 0, 0, 0);
    for (int i = 0; i < 3; i++) idle(1);
    #1;
    checkOutput("wrap.ret_b", {28'b0, ret_b}, 32'd1);
    checkOutput("wrap.ret_a", ret_a, 32'd17);
    for (int i = 0; i < 5; i++)
      applyStimulus(1, 0, 1, 5, 1, 5, 1, 5, 1, 1, 1, 0);
    #1;
    checkOutput("freeze.ret_a", ret_a, 32'd17);
    checkOutput("freeze.flcnt", flc_a, 32'd0);

    $display("[TB] reset during stall");
    doReset();
    issue(0, 0, 0, 0, 5, 1, 1, 0);
    applyStimulus(0, 1, 1, 5, 1, 0, 0, 6, 1, 0, 0, 0);
    #1;
    checkOutput("rststall.sv", {29'b0, sv_a}, 32'd0);
    checkOutput("rststall.stcnt", stc_a, 32'd0);
    issue(0, 0, 0, 0, 5, 1, 1, 0);
    applyStimulus(1, 1, 1, 5, 1, 0, 0, 6, 1, 0, 0, 1);
    #1;
    checkOutput("glitch.stcnt", stc_a, 32'd1);

    $display("[TB] random");
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 63) != 0), ($urandom_range(0, 7) != 0),
                    ($urandom_range(0, 3) != 0),
                    5'($urandom_range(0, 3)), 1'($urandom),
                    5'($urandom_range(0, 3)), 1'($urandom),
                    5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                    ($urandom_range(0, 7) == 0), 0);
    end
    idle(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
